// File: rtl/pip_stage_skid_reg.sv
// Two-entry valid/ready skid pipeline stage: registered outputs, falling-edge state, per-bit flush mask.
// Optional perf counters (stall_cnt / flush_cnt) are built only when PIP_PERF_CNT_EN is defined.
module pip_stage_skid_reg #(
    parameter int unsigned      WIDTH           = 300,
    parameter logic [WIDTH-1:0] FLUSH_KEEP_MASK = {236'b0, {32{1'b1}}, 32'b0},
    parameter int unsigned      CNT_W           = 16
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               m_valid_q, m_valid_d;
    logic [WIDTH-1:0]   m_data_q, m_data_d;
    logic               s_valid_q, s_valid_d;
    logic [WIDTH-1:0]   s_data_q, s_data_d;
    logic               in_ready_q, in_ready_d;
    logic               acc_s;
    logic               dep_s;

    assign acc_s = in_valid && in_ready_q;
    assign dep_s = m_valid_q && out_ready;

    // Next-state for both entries; flush overrides every transfer.
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
            state_d   = ST_EMPTY;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_data_d  = m_data_q & FLUSH_KEEP_MASK;
            s_data_d  = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_d   = ST_ONE;
                        m_valid_d = 1'b1;
                        m_data_d  = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && !dep_s) begin
                        state_d   = ST_FULL;
                        s_valid_d = 1'b1;
                        s_data_d  = in_data;
                    end else if (acc_s && dep_s) begin
                        state_d  = ST_ONE;
                        m_data_d = in_data;
                    end else if (dep_s) begin
                        state_d   = ST_EMPTY;
                        m_valid_d = 1'b0;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a departure can move the stage.
                    if (dep_s) begin
                        state_d   = ST_ONE;
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                        s_data_d  = {WIDTH{1'b0}};
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
        in_ready_d = !s_valid_d;
    end

    // Stage state register; in_ready_q also serves as the reset-done flag.
    always_ff @(negedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_EMPTY;
            m_valid_q  <= 1'b0;
            m_data_q   <= {WIDTH{1'b0}};
            s_valid_q  <= 1'b0;
            s_data_q   <= {WIDTH{1'b0}};
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign occupancy = state_q;

`ifdef PIP_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating perf counters, cleared only by reset.
    always_ff @(negedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= (m_valid_q && !out_ready) ? sat_inc(stall_cnt_q) : stall_cnt_q;
            flush_cnt_q <= (flush && (state_q != ST_EMPTY)) ? sat_inc(flush_cnt_q) : flush_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pip_stage_skid_reg.sv
// Scoreboard bench for pip_stage_skid_reg: driver pushes accepted payloads, monitor pops on each departure.
module tb_pip_stage_skid_reg;

    localparam int W = 300;
`ifdef PIP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b1;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    logic          s_iv, s_ordy, s_flush, s_in_ready, s_ov;
    logic [7:0]    s_in_data, s_out_data;
    logic [1:0]    s_occ;
    logic [3:0]    s_stall, s_flushc;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];

    pip_stage_skid_reg dut (
        .clk(clk), .Rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pip_stage_skid_reg #(.WIDTH(8), .FLUSH_KEEP_MASK(8'hF0), .CNT_W(4)) u_sat (
        .clk(clk), .Rst_n(rst_n), .flush(s_flush),
        .in_valid(s_iv), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall), .flush_cnt(s_flushc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pat(input logic [7:0] k);
        pat = {k, {35{8'hA5}}, 4'hC, k};
    endfunction

    // Monitor: every departure must match the oldest accepted payload.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got %h expected nothing", out_data);
            end else begin
                chk("out_data_order", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl,
                         input logic e_rdy, input logic e_ov, input logic [1:0] e_occ, input string tag);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        chk({tag, ".in_ready"},  W'(in_ready),  W'(e_rdy));
        chk({tag, ".out_valid"}, W'(out_valid), W'(e_ov));
        chk({tag, ".occupancy"}, W'(occupancy), W'(e_occ));
        if (fl) exp_q.delete();
        else if (iv && e_rdy) exp_q.push_back(d);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_iv = 1'b0; s_ordy = 1'b0; s_flush = 1'b0; s_in_data = 8'h5A;

        // 1: reset and release
        #7;
        chk("rst.out_valid", W'(out_valid), W'(1'b0));
        chk("rst.occupancy", W'(occupancy), W'(2'd0));
        chk("rst.out_data", out_data, {W{1'b0}});
        chk("rst.in_ready", W'(in_ready), W'(1'b0));
        #5 rst_n = 1'b1;
        #1 chk("rel.in_ready_before_edge", W'(in_ready), W'(1'b0));
        @(negedge clk); #1;
        chk("rel.in_ready_after_edge", W'(in_ready), W'(1'b1));

        // 2: streaming A1..A5
        for (int k = 1; k <= 5; k++)
            cycle(1'b1, pat(8'hA0 + 8'(k)), 1'b1, 1'b0, 1'b1, (k != 1), (k == 1) ? 2'd0 : 2'd1, "stream");
        cycle(1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "stream.drain");
        idle("stream.idle");

        // 3: backpressure fills skid, then drains in order
        cycle(1'b1, pat(8'hB1), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "bp.b1");
        cycle(1'b1, pat(8'hB2), 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "bp.b2");
        cycle(1'b1, pat(8'hB3), 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, "bp.full");
        cycle(1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, "bp.dep1");
        cycle(1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "bp.dep2");
        idle("bp.idle");

        // 4: flush from FULL, flush with input, flush with departure
        cycle(1'b1, {{59{4'h9}}, 64'h1234_5678_DEAD_BEEF}, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "fl.d1");
        cycle(1'b1, pat(8'hD2), 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "fl.d2");
        cycle(1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, "fl.full");
        idle("fl.after");
        chk("fl.masked_data", out_data, W'(64'h1234_5678_0000_0000));
        cycle(1'b1, pat(8'hD3), 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, "fl.with_in");
        idle("fl.discarded");
        chk("fl.empty_masked", out_data, W'(64'h1234_5678_0000_0000));
        cycle(1'b1, {{59{4'h3}}, 64'hCAFE_F00D_0BAD_F00D}, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "fl.d4");
        cycle(1'b1, pat(8'hD5), 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, "fl.dep");
        idle("fl.dep_after");
        chk("fl.dep_masked", out_data, W'(64'hCAFE_F00D_0000_0000));

        // 6: async reset while FULL
        cycle(1'b1, pat(8'hF1), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "ar.f1");
        cycle(1'b1, pat(8'hF2), 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "ar.f2");
        chk("ar.stall_before", W'(stall_cnt), W'(PERF ? 5 : 0));
        chk("ar.flush_before", W'(flush_cnt), W'(PERF ? 2 : 0));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.out_valid", W'(out_valid), W'(1'b0));
        chk("ar.occupancy", W'(occupancy), W'(2'd0));
        chk("ar.out_data", out_data, {W{1'b0}});
        chk("ar.in_ready", W'(in_ready), W'(1'b0));
        chk("ar.stall_cleared", W'(stall_cnt), {W{1'b0}});
        exp_q.delete();
        @(negedge clk); #1;
        chk("ar.in_ready_held", W'(in_ready), W'(1'b0));
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("ar.in_ready_rel", W'(in_ready), W'(1'b0));
        @(negedge clk); #1;
        chk("ar.in_ready_up", W'(in_ready), W'(1'b1));

        // 5: stall counting
        cycle(1'b1, pat(8'hE1), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "st.e1");
        for (int k = 0; k < 10; k++)
            cycle(1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "st.hold");
        chk("st.stall10", W'(stall_cnt), W'(PERF ? 10 : 0));
        chk("st.data_stable", out_data, pat(8'hE1));
        cycle(1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "st.drain");
        cycle(1'b1, pat(8'hE2), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "st.e2");
        cycle(1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, "st.flush");
        chk("st.stall11", W'(stall_cnt), W'(PERF ? 11 : 0));
        chk("st.flush1", W'(flush_cnt), W'(PERF ? 1 : 0));
        idle("st.idle");

        // 5b: saturation with a 4-bit counter
        s_iv = 1'b1;
        @(negedge clk); #1;
        s_iv = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("sat.stall10", W'(s_stall), W'(PERF ? 10 : 0));
        repeat (10) @(negedge clk);
        #1;
        chk("sat.stall15", W'(s_stall), W'(PERF ? 15 : 0));
        chk("sat.data", W'(s_out_data), W'(8'h5A));
        chk("sat.occ", W'(s_occ), W'(2'd1));
        chk("sat.in_ready", W'(s_in_ready), W'(1'b1));
        chk("sat.flush_cnt", W'(s_flushc), {W{1'b0}});
        s_ordy = 1'b1;
        @(negedge clk); #1;
        chk("sat.drained", W'(s_ov), W'(1'b0));

        chk("sb.all_delivered", W'(exp_q.size()), {W{1'b0}});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
